ahb_addr_decoder: RTL
=====================

# ahb_addr_decoder

Parametrised AHB address decoder with integrated default slave. It replaces the fixed two-slave decoder. The block decodes the address phase into one-hot slave selects for any number of equally sized slave regions, and registers the data-phase mux select. Unmapped or disabled regions are routed to an internal default slave, which returns the AHB two-cycle ERROR response and counts decode errors. It sits between the master's address bus and the slave/response multiplexer of the AHB fabric.

## Interface
- AHB_ADDR_WIDTH, 32, address bus width
- AHB_BASE_ADDR, 32'h20300000, fabric base address; only bits [AHB_ADDR_WIDTH-1:AHB_SPACE_WIDTH] are compared
- AHB_SPACE_WIDTH, 16, log2 of total fabric space in bytes
- REGION_WIDTH, 10, log2 of bytes per slave region; slave i occupies base + i·2^REGION_WIDTH
- SLAVE_DEVICES, 4, number of slaves N; must satisfy N ≤ 2^(AHB_SPACE_WIDTH-REGION_WIDTH)
- SLAVE_EN_MASK, {N{1'b1}}, bit i = 0 routes region i to the default slave
- ERR_CNT_WIDTH, 8, decode-error counter width
- ahb_clk_in  input  1  clock; single clock domain
- ahb_rstn_in  input  1  reset, synchronous, active-low
- ahb_addr_in  input  AHB_ADDR_WIDTH  HADDR
- ahb_trans_in  input  2  HTRANS (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ)
- ahb_ready_in  input  1  bus HREADY, fed back from the response mux
- err_clr_in  input  1  synchronous clear of the error counter
- slave_sel_out  output  N  one-hot HSEL for the address phase; combinational
- data_sel_out  output  $clog2(N+1)  registered data-phase mux index; 0 = default slave, i+1 = slave i
- def_ready_out  output  1  default slave HREADYOUT
- def_resp_out  output  1  default slave HRESP (1 = ERROR)
- err_cnt_out  output  ERR_CNT_WIDTH  saturating count of decode errors

## Operation
- Hit: address-phase inputs are decoded as a hit when all of the following hold:
  - addr[AW-1:SPACE_W] == AHB_BASE_ADDR[AW-1:SPACE_W]
  - idx = addr[SPACE_W-1:REGION_W] satisfies idx < N
  - SLAVE_EN_MASK[idx] = 1
- slave_sel_out: bit idx is set on a hit, otherwise all zeros. It does not depend on HTRANS; slaves qualify the select with HTRANS themselves.
- Address phase capture: on an edge with ahb_ready_in = 1:
  - data_sel_q ← hit ? idx+1 : 0
  - def_err_q ← !hit && ahb_trans_in[1]
- When ahb_ready_in = 0, all captured state holds.
- data_sel_out = data_sel_q.
- Default slave FSM states:
  - IDLE: def_ready_out = 1, def_resp_out = 0.
  - ERR1: def_ready_out = 0, def_resp_out = 1.
  - ERR2: def_ready_out = 1, def_resp_out = 1.
- FSM transitions:
  - IDLE→ERR1 on an ahb_ready_in = 1 edge that captures def_err = 1.
  - ERR1→ERR2 unconditionally.
  - ERR2→ERR1 if that edge captures a new erroring transfer (ahb_ready_in = 1 in ERR2), otherwise ERR2→IDLE.
- Default slave in a data phase for IDLE/BUSY transfers: stays in IDLE and returns OKAY with zero wait states.
- Error counter:
  - Increments by 1 on every entry into ERR1 and saturates at all ones.
  - err_clr_in has priority over a simultaneous increment; the result is 0.

## Timing
- Reset values applied at the first ahb_clk_in edge with ahb_rstn_in = 0:
  - data_sel_out = 0, FSM = IDLE, def_ready_out = 1, def_resp_out = 0, err_cnt_out = 0.
- slave_sel_out has no reset value; it is combinational.
- Reset mid-ERR1/ERR2 aborts the error response. The next cycle shows the IDLE outputs; the counter is zeroed.
- slave_sel_out has zero latency from address. data_sel_out and the FSM have one-cycle latency, gated by ahb_ready_in.
- ERROR response is exactly 2 cycles: ready 0 then 1, with resp = 1 in both cycles.
- Back-to-back erroring transfers produce a gapless ERR1, ERR2, ERR1, ERR2 sequence.
- Slave wait states (ahb_ready_in = 0) freeze data_sel_out for their full duration.

## Test plan
- Reset with default parameters:
  - Apply ahb_rstn_in = 0 for 2 cycles, then release.
  - Required: data_sel_out = 0, def_ready_out = 1, def_resp_out = 0, err_cnt_out = 0.
- Mapped decode:
  - NONSEQ to 0x20300C04 with ahb_ready_in = 1.
  - Required: slave_sel_out = 4'b1000 in the same cycle, data_sel_out = 4 on the next cycle, def outputs stay OKAY.
- Unmapped region (idx 4 ≥ N):
  - NONSEQ to 0x20301000.
  - Required: slave_sel_out = 0, then data_sel_out = 0 with ERR1 (ready 0, resp 1), then ERR2 (ready 1, resp 1), then IDLE.
  - Required: err_cnt_out = 1.
- Base mismatch and IDLE transfer:
  - IDLE transfer to 0x20400000.
  - Required: data_sel_out = 0, no ERROR, counter unchanged.
- Back-to-back errors and saturation:
  - With ERR_CNT_WIDTH = 2, issue 5 consecutive NONSEQ transfers to 0x20400000.
  - Required: a continuous ERR1/ERR2 sequence and err_cnt_out stuck at 3.
  - Then assert err_clr_in together with a new error; required: err_cnt_out = 0.
- Wait states and masking:
  - With SLAVE_EN_MASK = 4'b1101: NONSEQ to 0x20300400, required slave_sel_out = 0 and an ERROR response.
  - NONSEQ to 0x20300000 followed by 3 cycles of ahb_ready_in = 0: required data_sel_out = 1 held throughout.
  - Reset asserted during ERR1: required IDLE outputs on the next cycle.

Source files
------------

// File: rtl/ahb_addr_decoder.sv
// AHB address decoder: one-hot slave selects for equally sized regions, registered
// data-phase mux index, and a built-in default slave that answers unmapped accesses with ERROR.
module ahb_addr_decoder #(
    parameter int                          AHB_ADDR_WIDTH  = 32,
    parameter logic [AHB_ADDR_WIDTH-1:0]   AHB_BASE_ADDR   = 32'h20300000,
    parameter int                          AHB_SPACE_WIDTH = 16,
    parameter int                          REGION_WIDTH    = 10,
    parameter int                          SLAVE_DEVICES   = 4,
    parameter logic [SLAVE_DEVICES-1:0]    SLAVE_EN_MASK   = {SLAVE_DEVICES{1'b1}},
    parameter int                          ERR_CNT_WIDTH   = 8,
    localparam int                         DSEL_WIDTH      = $clog2(SLAVE_DEVICES + 1)
) (
    input  logic                       ahb_clk_in,
    input  logic                       ahb_rstn_in,
    input  logic [AHB_ADDR_WIDTH-1:0]  ahb_addr_in,
    input  logic [1:0]                 ahb_trans_in,
    input  logic                       ahb_ready_in,
    input  logic                       err_clr_in,
    output logic [SLAVE_DEVICES-1:0]   slave_sel_out,
    output logic [DSEL_WIDTH-1:0]      data_sel_out,
    output logic                       def_ready_out,
    output logic                       def_resp_out,
    output logic [ERR_CNT_WIDTH-1:0]   err_cnt_out
);

    localparam int IDX_WIDTH = AHB_SPACE_WIDTH - REGION_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } def_state_t;

    logic                     base_match;
    logic [IDX_WIDTH-1:0]     region_idx;
    logic [SLAVE_DEVICES-1:0] slave_sel;
    logic                     hit;
    logic [DSEL_WIDTH-1:0]    data_sel_next;
    logic                     err_entry;
    logic                     unused_addr_bits;

    def_state_t               state_reg;
    logic [DSEL_WIDTH-1:0]    data_sel_reg;
    logic                     def_ready_reg;
    logic                     def_resp_reg;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_reg;

    assign base_match = (ahb_addr_in[AHB_ADDR_WIDTH-1:AHB_SPACE_WIDTH]
                         == AHB_BASE_ADDR[AHB_ADDR_WIDTH-1:AHB_SPACE_WIDTH]);
    assign region_idx = ahb_addr_in[AHB_SPACE_WIDTH-1:REGION_WIDTH];
    assign unused_addr_bits = ^{ahb_addr_in[REGION_WIDTH-1:0], ahb_trans_in[0]};

    // Indices >= SLAVE_DEVICES never match any comparator, so they fall to the default slave.
    genvar gi;
    generate
        for (gi = 0; gi < SLAVE_DEVICES; gi++) begin : g_sel
            assign slave_sel[gi] = base_match && (region_idx == IDX_WIDTH'(gi))
                                   && SLAVE_EN_MASK[gi];
        end
    endgenerate

    assign hit = |slave_sel;

    always_comb begin
        data_sel_next = '0;
        for (int i = 0; i < SLAVE_DEVICES; i++) begin
            if (slave_sel[i]) begin
                data_sel_next = DSEL_WIDTH'(i + 1);
            end
        end
    end

    // ERR1 always advances to ERR2, so a capture during ERR1 cannot open a new error.
    assign err_entry = ahb_ready_in && !hit && ahb_trans_in[1] && (state_reg != ST_ERR1);

    always_ff @(posedge ahb_clk_in) begin
        if (!ahb_rstn_in) begin
            state_reg     <= ST_IDLE;
            data_sel_reg  <= '0;
            def_ready_reg <= 1'b1;
            def_resp_reg  <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            if (ahb_ready_in) begin
                data_sel_reg <= data_sel_next;
            end

            case (state_reg)
                ST_ERR1: begin
                    state_reg     <= ST_ERR2;
                    def_ready_reg <= 1'b1;
                    def_resp_reg  <= 1'b1;
                end
                default: begin
                    if (err_entry) begin
                        state_reg     <= ST_ERR1;
                        def_ready_reg <= 1'b0;
                        def_resp_reg  <= 1'b1;
                    end else begin
                        state_reg     <= ST_IDLE;
                        def_ready_reg <= 1'b1;
                        def_resp_reg  <= 1'b0;
                    end
                end
            endcase

            if (err_clr_in) begin
                err_cnt_reg <= '0;
            end else if (err_entry && (err_cnt_reg != '1)) begin
                err_cnt_reg <= err_cnt_reg + 1'b1;
            end
        end
    end

    assign slave_sel_out = slave_sel;
    assign data_sel_out  = data_sel_reg;
    assign def_ready_out = def_ready_reg;
    assign def_resp_out  = def_resp_reg;
    assign err_cnt_out   = err_cnt_reg;

endmodule
